// File: rtl/child_seq_pkg.sv
// -----------------------------------------------------------------------------
// child_seq_pkg
// Shared types and helpers for the child sequencing controller.
//   state_e      : controller FSM states
//   fail_code_e  : encoding reported on fail_code_o
//   IDX_W        : width of the child index (covers up to 16 children)
//   cnt_width()  : bits needed to hold a value 0..max_val (minimum 1)
// -----------------------------------------------------------------------------
package child_seq_pkg;

  localparam int IDX_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    FAIL  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    FAIL_NONE    = 2'd0,
    FAIL_CHILD   = 2'd1,
    FAIL_TIMEOUT = 2'd2,
    FAIL_ABORT   = 2'd3
  } fail_code_e;

  function automatic int cnt_width(input int max_val);
    if (max_val < 2) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/child_seq_ctrl_timer.sv
// -----------------------------------------------------------------------------
// child_seq_timer
// Loadable saturating down-counter used as the per-child timeout.
//   clk, rst     : clock, synchronous active-high reset
//   load_i       : load load_val_i (takes priority over en_i)
//   load_val_i   : value loaded on load_i
//   en_i         : decrement by one per cycle, stopping at zero
//   expired_o    : counter is at zero
// -----------------------------------------------------------------------------
module child_seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] r_count;

  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (load_i) begin
      r_count <= load_val_i;
    end else if (en_i && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign expired_o = (r_count == '0);

endmodule

// File: rtl/child_seq_ctrl.sv
// -----------------------------------------------------------------------------
// child_seq_ctrl
// Activates NUM_CHILDREN children strictly in index order with a req/done
// handshake, applies a per-child timeout and reports completion, the failing
// child and the elapsed cycle count to the parent.
//   clk, rst      : clock, synchronous active-high reset
//   start_i       : pulse starting a sequence (only honoured in IDLE)
//   abort_i       : cancels an active sequence (ISSUE/WAIT only)
//   child_req_o   : one-hot request to the active child (registered)
//   child_done_i  : per-child completion pulse
//   child_err_i   : per-child error, qualified by the matching done bit
//   busy_o        : sequence in progress (ISSUE, WAIT, DONE, FAIL)
//   done_o        : one-cycle pulse, all children completed cleanly
//   fail_o        : one-cycle pulse, child error / timeout / abort
//   fail_code_o   : fail_code_e of the last sequence, held until next start
//   fail_idx_o    : child index active at failure, held until next start
//   cycles_o      : busy cycles of the last sequence, saturating, held
// -----------------------------------------------------------------------------
module child_seq_ctrl
  import child_seq_pkg::*;
#(
  parameter int NUM_CHILDREN   = 5,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    abort_i,
  output logic [NUM_CHILDREN-1:0] child_req_o,
  input  logic [NUM_CHILDREN-1:0] child_done_i,
  input  logic [NUM_CHILDREN-1:0] child_err_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    fail_o,
  output logic [1:0]              fail_code_o,
  output logic [IDX_W-1:0]        fail_idx_o,
  output logic [CNT_W-1:0]        cycles_o
);

  localparam int               TMR_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES);

  // Registers
  state_e                  r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [NUM_CHILDREN-1:0] r_req;
  fail_code_e              r_fail_code;
  logic [IDX_W-1:0]        r_fail_idx;
  logic [CNT_W-1:0]        r_cycles;

  // Next-state / control wires
  state_e                  w_state_next;
  logic [IDX_W-1:0]        w_idx_next;
  logic [NUM_CHILDREN-1:0] w_req_next;
  fail_code_e              w_fail_code_next;
  logic [IDX_W-1:0]        w_fail_idx_next;
  logic                    w_cycles_clr;
  logic                    w_tmr_load;
  logic                    w_tmr_en;
  logic                    w_tmr_expired;

  // Decoded view of the active child; all other children's bits are ignored.
  logic [NUM_CHILDREN-1:0] w_sel;
  logic                    w_done_sel;
  logic                    w_err_sel;
  logic                    w_last;
  logic                    w_timeout;

  assign w_sel      = NUM_CHILDREN'(1) << r_idx;
  assign w_done_sel = |(child_done_i & w_sel);
  assign w_err_sel  = |(child_err_i & w_sel);
  assign w_last     = (r_idx == IDX_W'(NUM_CHILDREN - 1));
  // A zero timeout disables expiry entirely.
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && w_tmr_expired;

  child_seq_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (w_tmr_load),
    .load_val_i (TMR_LOAD),
    .en_i       (w_tmr_en),
    .expired_o  (w_tmr_expired)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_next     = r_state;
    w_idx_next       = r_idx;
    w_req_next       = r_req;
    w_fail_code_next = r_fail_code;
    w_fail_idx_next  = r_fail_idx;
    w_cycles_clr     = 1'b0;
    w_tmr_load       = 1'b0;
    w_tmr_en         = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (start_i) begin
          w_state_next     = ISSUE;
          w_idx_next       = '0;
          w_fail_code_next = FAIL_NONE;
          w_fail_idx_next  = '0;
          w_cycles_clr     = 1'b1;
        end
      end

      ISSUE: begin
        if (abort_i) begin
          w_state_next     = FAIL;
          w_fail_code_next = FAIL_ABORT;
          w_fail_idx_next  = r_idx;
          w_req_next       = '0;
        end else begin
          w_state_next = WAIT;
          w_req_next   = w_sel;
          w_tmr_load   = 1'b1;
        end
      end

      WAIT: begin
        w_tmr_en = 1'b1;
        // Priority: abort, then done (clean or error), then timeout.
        if (abort_i) begin
          w_state_next     = FAIL;
          w_fail_code_next = FAIL_ABORT;
          w_fail_idx_next  = r_idx;
          w_req_next       = '0;
        end else if (w_done_sel) begin
          w_req_next = '0;
          if (w_err_sel) begin
            w_state_next     = FAIL;
            w_fail_code_next = FAIL_CHILD;
            w_fail_idx_next  = r_idx;
          end else if (w_last) begin
            w_state_next = DONE;
          end else begin
            w_state_next = ISSUE;
            w_idx_next   = r_idx + IDX_W'(1);
          end
        end else if (w_timeout) begin
          w_state_next     = FAIL;
          w_fail_code_next = FAIL_TIMEOUT;
          w_fail_idx_next  = r_idx;
          w_req_next       = '0;
        end
      end

      DONE: begin
        w_state_next = IDLE;
      end

      FAIL: begin
        w_state_next = IDLE;
        w_req_next   = '0;
      end

      default: begin
        w_state_next = IDLE;
        w_req_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_req       <= '0;
      r_fail_code <= FAIL_NONE;
      r_fail_idx  <= '0;
      r_cycles    <= '0;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_req       <= w_req_next;
      r_fail_code <= w_fail_code_next;
      r_fail_idx  <= w_fail_idx_next;
      // Counts every busy cycle including the DONE/FAIL cycle, so the final
      // value is visible once the controller is back in IDLE.
      if (w_cycles_clr) begin
        r_cycles <= '0;
      end else if ((r_state != IDLE) && (r_cycles != '1)) begin
        r_cycles <= r_cycles + CNT_W'(1);
      end
    end
  end

  assign child_req_o = r_req;
  assign busy_o      = (r_state != IDLE);
  assign done_o      = (r_state == DONE);
  assign fail_o      = (r_state == FAIL);
  assign fail_code_o = r_fail_code;
  assign fail_idx_o  = r_fail_idx;
  assign cycles_o    = r_cycles;

endmodule

// File: tb/tb_child_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_child_seq_ctrl
// Directed stimulus with a scoreboard: scenarios push the expected request
// order and the expected done/fail event; a negedge monitor pops and compares
// whenever the DUT raises a request or pulses done_o/fail_o.
// -----------------------------------------------------------------------------
module tb_child_seq_ctrl;

  localparam int NC = 5;
  localparam int TO = 10;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          abort_i;
  logic [NC-1:0] child_req_o;
  logic [NC-1:0] child_done_i;
  logic [NC-1:0] child_err_i;
  logic          busy_o;
  logic          done_o;
  logic          fail_o;
  logic [1:0]    fail_code_o;
  logic [3:0]    fail_idx_o;
  logic [CW-1:0] cycles_o;

  child_seq_ctrl #(
    .NUM_CHILDREN   (NC),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .child_req_o  (child_req_o),
    .child_done_i (child_done_i),
    .child_err_i  (child_err_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .fail_o       (fail_o),
    .fail_code_o  (fail_code_o),
    .fail_idx_o   (fail_idx_o),
    .cycles_o     (cycles_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int code;
    int idx;
    int cycles;
    int gap;     // negedges from the last req rise to the pulse
  } evt_t;

  evt_t exp_evt[$];
  int   exp_req[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   cyc_pending = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  initial begin : monitor
    int            cyc;
    int            last_rise;
    int            cyc_exp;
    logic [NC-1:0] prev_req;
    evt_t          e;
    cyc       = 0;
    last_rise = 0;
    cyc_exp   = 0;
    prev_req  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc_pending) begin
        check("cycles_o after pulse", cycles_o, cyc_exp);
        cyc_pending = 1'b0;
      end
      check("req at most one-hot", 32'($onehot0(child_req_o)), 1);
      if ((prev_req == '0) && (child_req_o != '0)) begin
        last_rise = cyc;
        if (exp_req.size() == 0) check("unexpected req rise", child_req_o, 0);
        else check("req order", child_req_o, exp_req.pop_front());
      end
      prev_req = child_req_o;
      if (done_o || fail_o) begin
        if (exp_evt.size() == 0) begin
          check("unexpected done/fail pulse", {done_o, fail_o}, 0);
        end else begin
          e = exp_evt.pop_front();
          check("done_o", done_o, e.is_done);
          check("fail_o", fail_o, !e.is_done);
          check("fail_code_o", fail_code_o, e.code);
          check("fail_idx_o", fail_idx_o, e.idx);
          check("req cleared at pulse", child_req_o, 0);
          check("pulse gap from req rise", cyc - last_rise, e.gap);
          cyc_exp     = e.cycles;
          cyc_pending = 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_evt(input bit is_done, input int code, input int idx,
                          input int cycles, input int gap);
    evt_t e;
    e.is_done = is_done;
    e.code    = code;
    e.idx     = idx;
    e.cycles  = cycles;
    e.gap     = gap;
    exp_evt.push_back(e);
  endtask

  task automatic push_reqs(input int n);
    for (int k = 0; k < n; k++) exp_req.push_back(1 << k);
  endtask

  task automatic do_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("req low in ISSUE", child_req_o, 0);
    check("busy_o after start", busy_o, 1);
    tick();
  endtask

  // Waits (bounded) for req[k]; exp_wait is the number of cycles it should take.
  task automatic wait_req(input int k, input int exp_wait);
    int n;
    n = 0;
    while (!child_req_o[k] && (n < 64)) begin
      tick();
      n++;
    end
    if (!child_req_o[k]) check($sformatf("req[%0d] never rose", k), child_req_o[k], 1);
    else check($sformatf("req[%0d] latency", k), n, exp_wait);
  endtask

  task automatic respond(input int k, input int dly, input bit err, input bit ab);
    repeat (dly) tick();
    child_done_i = NC'(1) << k;
    child_err_i  = err ? (NC'(1) << k) : '0;
    abort_i      = ab;
    tick();
    child_done_i = '0;
    child_err_i  = '0;
    abort_i      = 1'b0;
    check("req low cycle after done", child_req_o, 0);
  endtask

  task automatic run_children(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      wait_req(k, (k == 0) ? 0 : 1);
      respond(k, 3, 1'b0, 1'b0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (((exp_evt.size() != 0) || cyc_pending) && (n < 40)) begin
      tick();
      n++;
    end
    check("expected events left", exp_evt.size(), 0);
    check("expected reqs left", exp_req.size(), 0);
    tick();
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst          = 1'b1;
    start_i      = 1'b0;
    abort_i      = 1'b0;
    child_done_i = '0;
    child_err_i  = '0;
    repeat (3) tick();
    check("reset busy_o", busy_o, 0);
    check("reset child_req_o", child_req_o, 0);
    check("reset fail_code_o", fail_code_o, 0);
    check("reset cycles_o", cycles_o, 0);
    rst = 1'b0;
    tick();

    // Nominal: every child answers 3 cycles after its req.
    push_reqs(5);
    push_evt(1'b1, 0, 0, 26, 4);
    do_start();
    run_children(0, 4);
    drain();

    // Child 2 reports an error; children 3 and 4 must never be requested.
    push_reqs(3);
    push_evt(1'b0, 1, 2, 16, 4);
    do_start();
    run_children(0, 1);
    wait_req(2, 1);
    respond(2, 3, 1'b1, 1'b0);
    drain();

    // Child 1 never answers: timeout fires 11 cycles after its req rises.
    push_reqs(2);
    push_evt(1'b0, 2, 1, 18, 11);
    do_start();
    run_children(0, 0);
    wait_req(1, 1);
    drain();

    // Abort in the same cycle as child 3's done: abort wins.
    push_reqs(4);
    push_evt(1'b0, 3, 3, 21, 4);
    do_start();
    run_children(0, 2);
    wait_req(3, 1);
    respond(3, 3, 1'b0, 1'b1);
    drain();

    // Abort while IDLE is ignored.
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort in IDLE busy_o", busy_o, 0);
    tick();

    // Stray start and inactive-child done/err during WAIT of child 1.
    push_reqs(5);
    push_evt(1'b1, 0, 0, 26, 4);
    do_start();
    run_children(0, 0);
    wait_req(1, 1);
    tick();
    start_i      = 1'b1;
    child_done_i = NC'(8);
    child_err_i  = NC'(8);
    tick();
    start_i      = 1'b0;
    child_done_i = '0;
    child_err_i  = '0;
    check("req held after stray inputs", child_req_o, 2);
    respond(1, 1, 1'b0, 1'b0);
    run_children(2, 4);
    drain();

    // Reset while waiting on child 4: all outputs zero next cycle, no pulse.
    push_reqs(5);
    do_start();
    run_children(0, 3);
    wait_req(4, 1);
    tick();
    rst = 1'b1;
    tick();
    check("mid-reset child_req_o", child_req_o, 0);
    check("mid-reset busy_o", busy_o, 0);
    check("mid-reset done_o", done_o, 0);
    check("mid-reset fail_o", fail_o, 0);
    check("mid-reset fail_code_o", fail_code_o, 0);
    check("mid-reset fail_idx_o", fail_idx_o, 0);
    check("mid-reset cycles_o", cycles_o, 0);
    rst = 1'b0;
    drain();

    // Full sequence after the reset starts again from child 0.
    push_reqs(5);
    push_evt(1'b1, 0, 0, 26, 4);
    do_start();
    run_children(0, 4);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
